// File: rtl/uart_pkg.sv
// Shared types and sampling constants for the oversampled UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam logic [3:0] SAMPLE_A  = 4'd7;
  localparam logic [3:0] SAMPLE_B  = 4'd8;
  localparam logic [3:0] SAMPLE_C  = 4'd9;
  localparam logic [3:0] SC_LAST   = 4'd15;
  localparam int         DATA_BITS = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// First-word-fall-through byte FIFO; rdata reads as zero while empty.
module uart_rx_byte_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign rdata = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled 8N1 receiver with majority-vote sampling, glitch rejection,
// sticky framing/overrun flags and a small FWFT byte FIFO towards the CPU.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baudclk16,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_read,
  input  logic       err_clr,
  output logic       frame_err,
  output logic       overrun
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;

  rx_state_e  state_q, state_d;
  logic [3:0] sc_q, sc_d;
  logic [2:0] bc_q, bc_d;
  logic [7:0] sh_q, sh_d;
  logic       samp_a_q, samp_a_d;
  logic       samp_b_q, samp_b_d;
  logic       rx_read_q, rx_read_d;
  logic       err_clr_q, err_clr_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;

  logic       maj;
  logic       push_req;
  logic       frame_set;
  logic       rd_edge;
  logic       clr_edge;
  logic       pop_eff;
  logic       fifo_push;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_rdata;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign maj    = majority3(samp_a_q, samp_b_q, rx_s);

  // Frame FSM: everything advances only on baud ticks. The third sample is
  // taken live at the decision tick rather than being stored.
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    bc_d      = bc_q;
    sh_d      = sh_q;
    samp_a_d  = samp_a_q;
    samp_b_d  = samp_b_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    if (baudclk16) begin
      if (state_q == START || state_q == DATA || state_q == STOP) begin
        sc_d = sc_q + 4'd1;
        if (sc_q == SAMPLE_A) samp_a_d = rx_s;
        if (sc_q == SAMPLE_B) samp_b_d = rx_s;
      end
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            sc_d    = 4'd0;
          end
        end
        START: begin
          if (sc_q == SAMPLE_C && maj) begin
            state_d = IDLE;
          end else if (sc_q == SC_LAST) begin
            state_d = DATA;
            bc_d    = 3'd0;
          end
        end
        DATA: begin
          if (sc_q == SAMPLE_C) begin
            sh_d = {maj, sh_q[7:1]};
          end
          if (sc_q == SC_LAST) begin
            if (bc_q == 3'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              bc_d = bc_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (sc_q == SAMPLE_C) begin
            if (maj) begin
              push_req = 1'b1;
              state_d  = IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // CPU handshake: level inputs are turned into single-cycle edges. A
  // coincident set beats the clear so no error event is ever lost.
  always_comb begin
    rx_read_d   = rx_read;
    err_clr_d   = err_clr;
    rd_edge     = rx_read && !rx_read_q;
    clr_edge    = err_clr && !err_clr_q;
    pop_eff     = rd_edge && !fifo_empty;
    fifo_push   = push_req && (!fifo_full || pop_eff);
    frame_err_d = frame_set || (frame_err_q && !clr_edge);
    overrun_d   = (push_req && fifo_full && !pop_eff) || (overrun_q && !clr_edge);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      sc_q        <= 4'd0;
      bc_q        <= 3'd0;
      sh_q        <= 8'h00;
      samp_a_q    <= 1'b1;
      samp_b_q    <= 1'b1;
      rx_read_q   <= 1'b0;
      err_clr_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      sc_q        <= sc_d;
      bc_q        <= bc_d;
      sh_q        <= sh_d;
      samp_a_q    <= samp_a_d;
      samp_b_q    <= samp_b_d;
      rx_read_q   <= rx_read_d;
      err_clr_q   <= err_clr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (pop_eff),
    .wdata(sh_q),
    .rdata(fifo_rdata),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign rx_data   = fifo_rdata;
  assign rx_ready  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
